// File: rtl/tick_countdown.sv
// Programmable tick-driven countdown timer: IDLE -> RUN -> DONE with a one-cycle done pulse.
// Optional build macro TICK_COUNTDOWN_PAUSE_EN adds a pause input that freezes counting in RUN.
module tick_countdown #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  input  logic             abort,
`ifdef TICK_COUNTDOWN_PAUSE_EN
  input  logic             pause,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   count_tick;

`ifdef TICK_COUNTDOWN_PAUSE_EN
  assign count_tick = tick & ~pause;
`else
  assign count_tick = tick;
`endif

  // busy/done are registered alongside the state so they always equal a decode of it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= load_value;
            if (load_value != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            remaining <= '0;
            state     <= IDLE;
          end else if (count_tick && remaining == WIDTH'(1)) begin
            remaining <= '0;
            state     <= DONE;
            done      <= 1'b1;
          end else begin
            if (count_tick && remaining != '0) begin
              remaining <= remaining - WIDTH'(1);
            end
            busy <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
        end
      endcase
    end
  end

endmodule
